// File: rtl/hwpe_stream_package.sv
// Shared definitions for the HWPE stream protocol checker: error class bit indices.
package hwpe_stream_package;

  localparam int unsigned SPURIOUS    = 0;
  localparam int unsigned OVERFLOW    = 1;
  localparam int unsigned TIMEOUT     = 2;
  localparam int unsigned NB_TCDM_ERR = 3;

  localparam int unsigned VCR           = 0;
  localparam int unsigned VDR           = 1;
  localparam int unsigned NB_STREAM_ERR = 2;

endpackage

// File: rtl/hwpe_stream_tcdm_checker_ch.sv
// Per-channel TCDM read checker: in-order queue of response ages plus the
// spurious / overflow / timeout detectors.
module hwpe_stream_tcdm_checker_ch
  import hwpe_stream_package::*;
#(
  parameter int unsigned MAX_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic                   gnt_i,
  input  logic                   wen_i,
  input  logic                   r_valid_i,
  output logic [NB_TCDM_ERR-1:0] events_o
);

  localparam int unsigned AW = $clog2(MAX_LATENCY + 1);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [AW-1:0] age_t;

  localparam age_t          AgeMax = AW'(MAX_LATENCY);
  localparam logic [CW-1:0] Full   = CW'(MAX_OUTSTANDING);

  // Entry 0 is always the oldest outstanding read.
  age_t [MAX_OUTSTANDING-1:0] age_q, age_d, age_sh;
  logic [CW-1:0]              cnt_q, cnt_d, cnt_rem;
  logic rd_hs, empty, full, pop, spurious, timeout, overflow, push, remove;

  always_comb begin
    rd_hs    = req_i & gnt_i & wen_i;
    empty    = (cnt_q == '0);
    full     = (cnt_q == Full);
    spurious = r_valid_i & empty;
    pop      = r_valid_i & ~empty;
    timeout  = ~r_valid_i & ~empty & (age_q[0] >= AgeMax);
    overflow = rd_hs & full & ~pop;
    push     = rd_hs & ~overflow;
    remove   = pop | timeout;

    // Removal happens before the push so a full queue can accept a read on a pop cycle.
    age_sh  = remove ? (age_q >> AW) : age_q;
    cnt_rem = cnt_q - CW'(remove);
    age_d   = '0;
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (CW'(i) < cnt_rem) begin
        age_d[i] = (age_sh[i] >= AgeMax) ? AgeMax : age_sh[i] + AW'(1);
      end else if (push && (CW'(i) == cnt_rem)) begin
        age_d[i] = AW'(1);
      end
    end
    cnt_d = cnt_rem + CW'(push);

    events_o           = '0;
    events_o[SPURIOUS] = spurious;
    events_o[OVERFLOW] = overflow;
    events_o[TIMEOUT]  = timeout;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age_q <= '0;
      cnt_q <= '0;
    end else begin
      age_q <= age_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hwpe_stream_protocol_checker.sv
// Observe-only protocol checker for HWPE TCDM channels and streams; reports
// sticky per-class flags and a saturating error-event counter.
module hwpe_stream_protocol_checker
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_TCDM         = 4,
  parameter int unsigned NB_STREAM       = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned MAX_LATENCY     = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            enable_i,
  input  logic [NB_TCDM-1:0]              tcdm_req_i,
  input  logic [NB_TCDM-1:0]              tcdm_gnt_i,
  input  logic [NB_TCDM-1:0]              tcdm_wen_i,
  input  logic [NB_TCDM-1:0]              tcdm_r_valid_i,
  input  logic [NB_STREAM-1:0]            stream_valid_i,
  input  logic [NB_STREAM-1:0]            stream_ready_i,
  input  logic [NB_STREAM*DATA_WIDTH-1:0] stream_data_i,
  input  logic [NB_STREAM*STRB_WIDTH-1:0] stream_strb_i,
  output logic [NB_TCDM*3-1:0]            err_tcdm_o,
  output logic [NB_STREAM*2-1:0]          err_stream_o,
  output logic                            err_o,
  output logic [CNT_WIDTH-1:0]            err_count_o
);

  localparam int unsigned NT    = NB_TCDM * NB_TCDM_ERR;
  localparam int unsigned NS    = NB_STREAM * NB_STREAM_ERR;
  localparam int unsigned NB_EV = NT + NS;
  localparam int unsigned PW    = $clog2(NB_EV + 1);
  localparam int unsigned SW    = CNT_WIDTH + PW;

  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic [NT-1:0]                   tcdm_ev;
  logic [NS-1:0]                   stream_ev;
  logic [NB_EV-1:0]                ev, flags_q, flags_d;
  logic [PW-1:0]                   ev_cnt;
  logic [SW-1:0]                   sum;
  logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
  logic [NB_STREAM-1:0]            valid_q, ready_q;
  logic [NB_STREAM*DATA_WIDTH-1:0] data_q;
  logic [NB_STREAM*STRB_WIDTH-1:0] strb_q;

  for (genvar c = 0; c < NB_TCDM; c++) begin : gen_tcdm
    hwpe_stream_tcdm_checker_ch #(
      .MAX_LATENCY     (MAX_LATENCY),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) i_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (tcdm_req_i[c]),
      .gnt_i     (tcdm_gnt_i[c]),
      .wen_i     (tcdm_wen_i[c]),
      .r_valid_i (tcdm_r_valid_i[c]),
      .events_o  (tcdm_ev[c*NB_TCDM_ERR +: NB_TCDM_ERR])
    );
  end

  // A stalled beat (valid & ~ready last cycle) must hold both valid and payload.
  always_comb begin
    stream_ev = '0;
    for (int s = 0; s < int'(NB_STREAM); s++) begin
      stream_ev[s*NB_STREAM_ERR+VCR] = valid_q[s] & ~ready_q[s] &
          ((stream_data_i[s*DATA_WIDTH +: DATA_WIDTH] != data_q[s*DATA_WIDTH +: DATA_WIDTH]) ||
           (stream_strb_i[s*STRB_WIDTH +: STRB_WIDTH] != strb_q[s*STRB_WIDTH +: STRB_WIDTH]));
      stream_ev[s*NB_STREAM_ERR+VDR] = valid_q[s] & ~ready_q[s] & ~stream_valid_i[s];
    end
  end

  always_comb begin
    ev     = enable_i ? {stream_ev, tcdm_ev} : '0;
    ev_cnt = '0;
    for (int i = 0; i < int'(NB_EV); i++) begin
      ev_cnt = ev_cnt + PW'(ev[i]);
    end
    sum = SW'(cnt_q) + SW'(ev_cnt);
    if (clear_i) begin
      flags_d = '0;
      cnt_d   = '0;
    end else begin
      flags_d = flags_q | ev;
      cnt_d   = (sum > SW'(CntMax)) ? CntMax : sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      ready_q <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      valid_q <= stream_valid_i;
      ready_q <= stream_ready_i;
      data_q  <= stream_data_i;
      strb_q  <= stream_strb_i;
    end
  end

  assign err_tcdm_o   = flags_q[NT-1:0];
  assign err_stream_o = flags_q[NB_EV-1:NT];
  assign err_o        = |flags_q;
  assign err_count_o  = cnt_q;

endmodule

// File: tb/tb_hwpe_stream_protocol_checker.sv
// Randomized bench comparing the checker against a timestamp-queue reference model.
module tb_hwpe_stream_protocol_checker;

  localparam int unsigned NT = 2;
  localparam int unsigned NS = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned SB = 1;
  localparam int unsigned ML = 3;
  localparam int unsigned MO = 2;
  localparam int unsigned CW = 4;
  localparam int          CNT_SAT = (1 << CW) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear, enable;
  logic [NT-1:0]      req, gnt, wen, r_valid;
  logic [NS-1:0]      s_valid, s_ready;
  logic [NS*DW-1:0]   s_data;
  logic [NS*SB-1:0]   s_strb;
  logic [NT*3-1:0]    err_tcdm;
  logic [NS*2-1:0]    err_stream;
  logic               err;
  logic [CW-1:0]      err_count;

  always #5 clk = ~clk;

  hwpe_stream_protocol_checker #(
    .NB_TCDM         (NT),
    .NB_STREAM       (NS),
    .DATA_WIDTH      (DW),
    .STRB_WIDTH      (SB),
    .MAX_LATENCY     (ML),
    .MAX_OUTSTANDING (MO),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .enable_i       (enable),
    .tcdm_req_i     (req),
    .tcdm_gnt_i     (gnt),
    .tcdm_wen_i     (wen),
    .tcdm_r_valid_i (r_valid),
    .stream_valid_i (s_valid),
    .stream_ready_i (s_ready),
    .stream_data_i  (s_data),
    .stream_strb_i  (s_strb),
    .err_tcdm_o     (err_tcdm),
    .err_stream_o   (err_stream),
    .err_o          (err),
    .err_count_o    (err_count)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each outstanding read is remembered by the cycle it was granted.
  int              q [NT][$];
  int              cyc = 0;
  bit [NT*3-1:0]   m_tcdm;
  bit [NS*2-1:0]   m_stream;
  int              m_cnt;
  bit              pv [NS];
  bit              pr [NS];
  logic [DW-1:0]   pd [NS];
  logic [SB-1:0]   ps [NS];

  task automatic model_reset();
    for (int c = 0; c < NT; c++) q[c].delete();
    m_tcdm   = '0;
    m_stream = '0;
    m_cnt    = 0;
    for (int s = 0; s < NS; s++) begin
      pv[s] = 1'b0;
      pr[s] = 1'b0;
      pd[s] = '0;
      ps[s] = '0;
    end
  endtask

  task automatic model_step();
    bit [NT*3-1:0] et;
    bit [NS*2-1:0] es;
    int            n;
    bit            h, r, nonempty, spur, pop, to, ov;
    et = '0;
    es = '0;
    for (int c = 0; c < NT; c++) begin
      h        = req[c] && gnt[c] && wen[c];
      r        = r_valid[c];
      nonempty = q[c].size() > 0;
      spur     = r && !nonempty;
      pop      = r && nonempty;
      to       = !r && nonempty && ((cyc - q[c][0]) >= ML);
      ov       = h && (q[c].size() == MO) && !pop;
      if (pop || to) void'(q[c].pop_front());
      if (h && !ov) q[c].push_back(cyc);
      et[c*3+0] = spur;
      et[c*3+1] = ov;
      et[c*3+2] = to;
    end
    for (int s = 0; s < NS; s++) begin
      bit stalled;
      stalled   = pv[s] && !pr[s];
      es[s*2+0] = stalled && ((s_data[s*DW +: DW] != pd[s]) || (s_strb[s*SB +: SB] != ps[s]));
      es[s*2+1] = stalled && !s_valid[s];
      pv[s] = s_valid[s];
      pr[s] = s_ready[s];
      pd[s] = s_data[s*DW +: DW];
      ps[s] = s_strb[s*SB +: SB];
    end
    n = $countones(et) + $countones(es);
    if (clear) begin
      m_tcdm   = '0;
      m_stream = '0;
      m_cnt    = 0;
    end else if (enable) begin
      m_tcdm   = m_tcdm | et;
      m_stream = m_stream | es;
      m_cnt    = (m_cnt + n > CNT_SAT) ? CNT_SAT : m_cnt + n;
    end
    cyc++;
  endtask

  task automatic check_outputs(input string when);
    check_eq({when, "_tcdm"},   32'(err_tcdm),   32'(m_tcdm));
    check_eq({when, "_stream"}, 32'(err_stream), 32'(m_stream));
    check_eq({when, "_err"},    32'(err),        32'(|{m_tcdm, m_stream}));
    check_eq({when, "_count"},  32'(err_count),  32'(m_cnt));
  endtask

  task automatic drive_random();
    clear  = ($urandom_range(0, 24) == 0);
    enable = ($urandom_range(0, 7) != 0);
    for (int c = 0; c < NT; c++) begin
      req[c]     = $urandom_range(0, 1);
      gnt[c]     = ($urandom_range(0, 3) != 0);
      wen[c]     = ($urandom_range(0, 3) != 0);
      r_valid[c] = ($urandom_range(0, 2) == 0);
    end
    for (int s = 0; s < NS; s++) begin
      s_valid[s] = ($urandom_range(0, 5) != 0);
      s_ready[s] = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) s_data[s*DW +: DW] = $urandom_range(0, 1) ? 8'hA5 : 8'h5A;
      if ($urandom_range(0, 9) == 0) s_strb[s*SB +: SB] = ~s_strb[s*SB +: SB];
    end
  endtask

  initial begin
    clear   = 1'b0;
    enable  = 1'b1;
    req     = '0;
    gnt     = '0;
    wen     = '0;
    r_valid = '0;
    s_valid = '0;
    s_ready = '0;
    s_data  = '0;
    s_strb  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) begin
        // Asynchronous reset pulse in the middle of a cycle.
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midreset");
        #1;
        rst_n = 1'b1;
      end
      drive_random();
      @(posedge clk);
      model_step();
      #1;
      check_outputs("run");
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_protocol_checker.md
# hwpe_stream_protocol_checker

Synthesizable protocol checker for HWPE streamer ports. It monitors `NB_TCDM` TCDM channels and `NB_STREAM` streams and reports violations as sticky flags plus a saturating counter. It generalises the fixed simulation-only rules to arbitrary read latency, outstanding depth, data width and channel count, so the rules also hold behind FIFOs. It sits beside an accelerator's streamer, observes only, and drives nothing on the monitored buses.

## Interface
- `NB_TCDM`, default 4: number of TCDM channels monitored.
- `NB_STREAM`, default 2: number of streams monitored.
- `DATA_WIDTH`, default 32: stream data width.
- `STRB_WIDTH`, default `DATA_WIDTH/8`: stream strobe width.
- `MAX_LATENCY`, default 1: maximum number of cycles from a read grant to its `r_valid`, at least 1.
- `MAX_OUTSTANDING`, default 4: maximum number of reads in flight per channel, at least 1.
- `CNT_WIDTH`, default 16: width of the error counter.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `clear_i`, in, 1: synchronous clear of the flags and the counter.
- `enable_i`, in, 1: enables error reporting.
- `tcdm_req_i`, `tcdm_gnt_i`, `tcdm_wen_i`, `tcdm_r_valid_i`, in, `NB_TCDM` each: per-channel TCDM control. `wen=1` means read.
- `stream_valid_i`, `stream_ready_i`, in, `NB_STREAM` each: per-stream handshake.
- `stream_data_i`, in, `NB_STREAM*DATA_WIDTH`: stream data, with stream i at slice i.
- `stream_strb_i`, in, `NB_STREAM*STRB_WIDTH`: stream strobes.
- `err_tcdm_o`, out, `NB_TCDM*3`: sticky flags per channel, bits {timeout, overflow, spurious}.
- `err_stream_o`, out, `NB_STREAM*2`: sticky flags per stream, bits {valid_deassert, value_change}.
- `err_o`, out, 1: OR of all sticky flags.
- `err_count_o`, out, `CNT_WIDTH`: saturating count of error events.

## Operation
- **Read handshake:** `req & gnt & wen`. Each channel keeps an in-order queue of `MAX_OUTSTANDING` saturating age counters.
- **Push:** a read handshake pushes an entry with age 1, valid from the next cycle.
- **Pop:** `r_valid` pops the oldest entry.
- **Same-cycle pop and push:** the pop is applied first.
- **Aging:** each held entry's age increments every cycle.
- **Spurious:** `r_valid` while the queue is empty. A grant in the same cycle does not satisfy it, since the minimum latency is 1.
- **Overflow:** a read handshake when the queue is full and no pop happens that cycle. The grant is not recorded.
- **Timeout:** the oldest entry reaches age `MAX_LATENCY` and `r_valid` is low. The entry is dropped to resynchronise. A later response to it is then flagged spurious.
- **Value change:** in the previous cycle `valid & ~ready`, and in the current cycle data or strb differs from its previous value. The check is applied regardless of the current `valid`.
- **Valid deassert:** in the previous cycle `valid & ~ready`, and in the current cycle `valid=0`.
- **Previous-cycle registers:** stored valid, ready, data and strb per stream. They reset to 0, so no false error occurs in the first cycle.
- **Reporting gate:**
  - When `enable_i=1`, each detected event sets its flag and adds to the counter.
  - When `enable_i=0`, detection still runs and the queues still update, but no flag or count changes.
- **Counter:** `err_count_o` adds the popcount of the events in a cycle and saturates at `2^CNT_WIDTH-1`.
- **Clear:** `clear_i` zeroes the flags and the counter but not the queues or the history registers. If `clear_i` and a new event occur in the same cycle, the clear wins.

## Timing
- **Reset:** every output is 0. The queues are empty and the history registers are 0.
- **Flag latency:** a violation sampled at edge N appears on the outputs after edge N, i.e. 1 cycle later. `err_o` is combinational from the flags.
- **Reset mid-operation:** `rst_ni` low immediately empties all queues and clears all outputs. Responses arriving after release are spurious.
- **Backward compatibility:** `MAX_LATENCY=1` reproduces the fixed zero-latency TCDM rule.

## Structure
- **Shared package:** the error class indices for TCDM (`SPURIOUS=0`, `OVERFLOW=1`, `TIMEOUT=2`) and for streams (`VCR=0`, `VDR=1`) live in `hwpe_stream_package`.
- **Sub-module:** `hwpe_stream_tcdm_checker_ch` holds the per-channel age queue and the three event detectors. It is generated `NB_TCDM` times.
- **Top level:** the stream checks, flag registers and counter stay in the top module.

## Test plan
- **Timeout:** `MAX_LATENCY=2`, read grant in cycle 0, `r_valid` in cycle 2 → no error. Repeat with `r_valid` low in cycles 1–2 → timeout flag high from cycle 3. `r_valid` in cycle 3 → spurious flag, `err_count_o=2`.
- **Overflow:** `MAX_OUTSTANDING=2`, `MAX_LATENCY=8`, reads granted in cycles 0, 1, 2 with no `r_valid` → overflow in cycle 3, count 1. Then 2 `r_valid` → no further error.
- **Value change:** `valid=1`, `ready=0`, data `0xA5` then `0x5A` → value_change flag. Same data with `strb` changed → flag. With `ready=1` in between → no flag.
- **Valid deassert:** `valid=1`, `ready=0`, then `valid=0` → valid_deassert flag. With `enable_i=0` → no flag and count 0.
- **Reset mid-operation:** 3 outstanding reads, `rst_ni` pulsed low mid-cycle → outputs 0 immediately. `r_valid` after release → spurious, count 1.
- **Saturation and clear:** `CNT_WIDTH=2`, 5 spurious events on 2 channels, including 2 in the same cycle → count 3. `clear_i` → flags and count 0 next cycle. `clear_i` together with an event → count 0.
